// File: rtl/readout_scheduler.sv
// readout_scheduler
// Serves the pixel-group priority encoders that share one hit path. At each
// frame it latches which groups report hits, serves them lowest index first,
// scans each served encoder over 8 slots and queues the decoded hits in a
// first-word-fall-through FIFO towards the serializer.
// Optional feature: define HIT_FRAME_ID_EN to prefix every hit word with an
// 8-bit frame id (hit_data becomes GROUP_W+11 bits wide instead of GROUP_W+3).
module readout_scheduler #(
    parameter int N_GROUPS   = 4,
    parameter int GROUP_W    = 2,
    parameter int FIFO_DEPTH = 16,
`ifdef HIT_FRAME_ID_EN
    localparam int HIT_W     = GROUP_W + 11
`else
    localparam int HIT_W     = GROUP_W + 3
`endif
) (
    input  logic                  clk,
    input  logic                  reset_sched,
    input  logic                  frame_start,
    input  logic [N_GROUPS-1:0]   group_hit,
    input  logic [4*N_GROUPS-1:0] addr_in,
    output logic [N_GROUPS-1:0]   read,
    output logic [N_GROUPS-1:0]   reset_encoder,
    output logic                  hit_valid,
    output logic [HIT_W-1:0]      hit_data,
    input  logic                  hit_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_ARB   = 3'd2;
    localparam logic [2:0] ST_CLEAR = 3'd3;
    localparam logic [2:0] ST_SCAN  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Index of the lowest set bit; the loop runs downward so the lowest wins.
    function automatic logic [GROUP_W-1:0] lowest_index(input logic [N_GROUPS-1:0] mask);
        logic [GROUP_W-1:0] idx;
        idx = '0;
        for (int i = N_GROUPS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = GROUP_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [N_GROUPS-1:0] one_hot(input logic [GROUP_W-1:0] idx);
        logic [N_GROUPS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [2:0]          state_r, state_s;
    logic [N_GROUPS-1:0] pending_r, pending_s;
    logic [GROUP_W-1:0]  sel_r, sel_s;
    logic [3:0]          cnt_r, cnt_s;
    logic [3:0]          addr_sel_s;
    logic                push_s;
    logic [HIT_W-1:0]    push_word_s;
    logic [N_GROUPS-1:0] read_s, reset_encoder_s;

    assign addr_sel_s = addr_in[{sel_r, 2'b00} +: 4];

`ifdef HIT_FRAME_ID_EN
    logic [7:0] frame_cnt_r;
    logic [7:0] frame_id_r;

    // Frame counter: tag the accepted frame with the count so far, then advance (wraps at 255).
    always_ff @(posedge clk or posedge reset_sched) begin
        if (reset_sched) begin
            frame_cnt_r <= 8'd0;
            frame_id_r  <= 8'd0;
        end else if ((state_r == ST_IDLE) && frame_start) begin
            frame_id_r  <= frame_cnt_r;
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end
    end

    assign push_word_s = {frame_id_r, sel_r, addr_sel_s[3:1]};
`else
    assign push_word_s = {sel_r, addr_sel_s[3:1]};
`endif

    // Frame sequencing: next state, pending mask, selected group, scan counter and hit push.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        sel_s     = sel_r;
        cnt_s     = cnt_r;
        push_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                pending_s = group_hit;
                if (group_hit == '0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ARB;
                end
            end
            ST_ARB: begin
                if (pending_r != '0) begin
                    sel_s     = lowest_index(pending_r);
                    pending_s = pending_r & ~one_hot(lowest_index(pending_r));
                    state_s   = ST_CLEAR;
                end else begin
                    state_s   = ST_DONE;
                end
            end
            ST_CLEAR: begin
                cnt_s   = 4'd0;
                state_s = ST_SCAN;
            end
            ST_SCAN: begin
                // cnt 1..8 sees the encoder answer to the read issued one cycle earlier
                if ((cnt_r != 4'd0) && addr_sel_s[0]) begin
                    push_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
                if (cnt_r == 4'd8) begin
                    cnt_s   = 4'd0;
                    state_s = ST_ARB;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                    state_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Encoder strobes decoded from the next state so the registered outputs line up with it.
    always_comb begin
        read_s          = '0;
        reset_encoder_s = '0;
        if ((state_s == ST_SCAN) && (cnt_s <= 4'd7)) begin
            read_s = one_hot(sel_s);
        end else begin
            read_s = '0;
        end
        if (state_s == ST_CLEAR) begin
            reset_encoder_s = one_hot(sel_s);
        end else begin
            reset_encoder_s = '0;
        end
    end

    // Control state and registered control outputs.
    always_ff @(posedge clk or posedge reset_sched) begin
        if (reset_sched) begin
            state_r       <= ST_IDLE;
            pending_r     <= '0;
            sel_r         <= '0;
            cnt_r         <= 4'd0;
            read          <= '0;
            reset_encoder <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_r       <= state_s;
            pending_r     <= pending_s;
            sel_r         <= sel_s;
            cnt_r         <= cnt_s;
            read          <= read_s;
            reset_encoder <= reset_encoder_s;
            busy          <= (state_s != ST_IDLE);
            frame_done    <= (state_s == ST_DONE);
        end
    end

    logic [HIT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             pop_s, full_s, wr_en_s, drop_s;
    logic [HIT_W-1:0] head_s;

    // FIFO bookkeeping; a push on full is only accepted when a pop frees the slot this cycle.
    always_comb begin
        pop_s    = hit_valid && hit_ready;
        full_s   = (count_r == CNT_W'(FIFO_DEPTH));
        wr_en_s  = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
        // next head word, bypassing the write when it lands in the head slot
        if (count_s == '0) begin
            head_s = '0;
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = push_word_s;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // FIFO pointers, occupancy, registered head word and sticky overflow.
    always_ff @(posedge clk or posedge reset_sched) begin
        if (reset_sched) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            hit_valid <= 1'b0;
            hit_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r  <= rd_ptr_s;
            count_r   <= count_s;
            hit_valid <= (count_s != '0);
            hit_data  <= head_s;
            if (drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_word_s;
        end
    end

endmodule

// File: tb/tb_readout_scheduler.sv
// tb_readout_scheduler: directed frames plus randomized frames for readout_scheduler.
// The encoders are modelled in the bench; expected hit streams are computed from the
// group/pixel masks directly (served groups ascending, pixels ascending).
module tb_readout_scheduler;

    localparam int NG    = 4;
    localparam int GW    = 2;
    localparam int DEPTH = 16;
`ifdef HIT_FRAME_ID_EN
    localparam int HW    = GW + 11;
`else
    localparam int HW    = GW + 3;
`endif

    logic            clk = 1'b0;
    logic            reset_sched;
    logic            frame_start;
    logic [NG-1:0]   group_hit;
    logic [4*NG-1:0] addr_in;
    logic [NG-1:0]   read;
    logic [NG-1:0]   reset_encoder;
    logic            hit_valid;
    logic [HW-1:0]   hit_data;
    logic            hit_ready;
    logic            busy;
    logic            frame_done;
    logic            overflow;

    readout_scheduler #(.N_GROUPS(NG), .GROUP_W(GW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_sched(reset_sched), .frame_start(frame_start),
        .group_hit(group_hit), .addr_in(addr_in), .read(read),
        .reset_encoder(reset_encoder), .hit_valid(hit_valid), .hit_data(hit_data),
        .hit_ready(hit_ready), .busy(busy), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [7:0]    mask   [NG];
    logic [7:0]    remain [NG];
    int            slot   [NG];
    bit            prio_mode;
    logic [HW-1:0] exp_q [$];
    int            cyc;
    int            done_cnt;
    int            done_cyc;
    int            rd_total;
    int            order_code;
    logic [7:0]    n_frames;
    logic [7:0]    cur_id;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] word(input int g, input int p);
`ifdef HIT_FRAME_ID_EN
        return {cur_id, GW'(g), 3'(p)};
`else
        return {GW'(g), 3'(p)};
`endif
    endfunction

    // One clock: sample this cycle, step the edge, then check pops and update the encoder model.
    task automatic tick();
        logic          pop;
        logic [HW-1:0] pd;
        logic [HW-1:0] e;
        logic [NG-1:0] rd;
        logic [NG-1:0] re;
        pop = hit_valid && hit_ready;
        pd  = hit_data;
        rd  = read;
        re  = reset_encoder;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("pop_data", pd, e);
        end
        for (int g = 0; g < NG; g++) begin
            logic [3:0] a;
            bit         found;
            a     = 4'($urandom);
            found = 1'b0;
            if (re[g]) begin
                slot[g]    = 0;
                remain[g]  = mask[g];
                order_code = order_code * 16 + g + 1;
            end
            if (rd[g]) begin
                rd_total++;
                a = 4'h0;
                if (prio_mode) begin
                    for (int p = 0; p < 8; p++) begin
                        if (remain[g][p] && !found) begin
                            a            = {3'(p), 1'b1};
                            remain[g][p] = 1'b0;
                            found        = 1'b1;
                        end
                    end
                end else if (mask[g][slot[g]]) begin
                    a = {3'(slot[g]), 1'b1};
                end
                slot[g]++;
            end
            addr_in[4*g +: 4] = a;
        end
    endtask

    // Queue the expected hits for a frame and return served-group count and order code.
    task automatic expect_frame(input logic [NG-1:0] gh, output int n, output int code);
        n      = 0;
        code   = 0;
        cur_id = n_frames;
        n_frames++;
        for (int g = 0; g < NG; g++) begin
            if (gh[g]) begin
                n++;
                code = code * 16 + g + 1;
                for (int p = 0; p < 8; p++) begin
                    if (mask[g][p]) exp_q.push_back(word(g, p));
                end
            end
        end
    endtask

    task automatic run_frame(input logic [NG-1:0] gh, input int ready_pct, input bit inject, input string tag);
        int n;
        int code;
        int start;
        expect_frame(gh, n, code);
        group_hit  = gh;
        done_cnt   = 0;
        done_cyc   = -1;
        rd_total   = 0;
        order_code = 0;
        start      = cyc;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (done_cnt > 0 && !busy && exp_q.size() == 0 && !hit_valid) break;
            frame_start = inject && (n > 0) && (k == 4);
            hit_ready   = ($urandom_range(0, 99) < ready_pct);
            tick();
        end
        frame_start = 1'b0;
        hit_ready   = 1'b0;
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc - start, (n == 0) ? 2 : 3 + 11 * n);
        check({tag, "_order"}, order_code, code);
        check({tag, "_reads"}, rd_total, 8 * n);
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_overflow"}, overflow, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read"}, read, '0);
        check({tag, "_reset_encoder"}, reset_encoder, '0);
        check({tag, "_hit_valid"}, hit_valid, 1'b0);
        check({tag, "_hit_data"}, hit_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        int n;
        int code;
        int start;
        reset_sched = 1'b1;
        frame_start = 1'b0;
        hit_ready   = 1'b0;
        group_hit   = '0;
        addr_in     = '0;
        prio_mode   = 1'b0;
        cyc         = 0;
        n_frames    = 8'd0;
        cur_id      = 8'd0;
        for (int g = 0; g < NG; g++) begin
            mask[g]   = 8'h00;
            remain[g] = 8'h00;
            slot[g]   = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_sched = 1'b0;
        tick();

        // T1: no groups -> immediate done
        run_frame(4'b0000, 100, 1'b0, "T1");

        // T2: group 2 with pixels 1 and 6
        mask[2] = 8'b0100_0010;
        run_frame(4'b0100, 50, 1'b0, "T2");

        // T3: groups 0,1,3 one pixel each; group 2 has pixels but is not reported
        mask[0] = 8'b0000_1000;
        mask[1] = 8'b1000_0000;
        mask[2] = 8'b1111_1111;
        mask[3] = 8'b0000_0001;
        run_frame(4'b1011, 100, 1'b1, "T3");

        // randomized frames, both encoder answer styles
        for (int f = 0; f < 24; f++) begin
            logic [NG-1:0] gh;
            int            total;
            gh        = NG'($urandom);
            prio_mode = $urandom_range(0, 1);
            total     = 0;
            for (int g = 0; g < NG; g++) begin
                mask[g] = 8'($urandom) & 8'($urandom);
                if (gh[g]) total += $countones(mask[g]);
            end
            run_frame(gh, (total > DEPTH) ? 100 : $urandom_range(20, 100), $urandom_range(0, 1), "RND");
        end

        // T4: 24 hits with no consumer; first 16 kept, overflow sticky
        prio_mode = 1'b0;
        mask[0] = 8'hFF;
        mask[1] = 8'hFF;
        mask[2] = 8'hFF;
        mask[3] = 8'h5A;
        expect_frame(4'b0111, n, code);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        group_hit   = 4'b0111;
        done_cnt    = 0;
        done_cyc    = -1;
        start       = cyc;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done_cnt > 0 && !busy) break;
            tick();
        end
        check("T4_done_cycle", done_cyc - start, 3 + 11 * n);
        check("T4_overflow", overflow, 1'b1);
        check("T4_valid_full", hit_valid, 1'b1);
        hit_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        hit_ready = 1'b0;
        tick();
        check("T4_drained", exp_q.size(), 0);
        check("T4_empty", hit_valid, 1'b0);
        check("T4_overflow_sticky", overflow, 1'b1);

        // T5: reset in the middle of a scan
        mask[0]     = 8'hFF;
        group_hit   = 4'b0001;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (read != '0) break;
            tick();
        end
        repeat (4) tick();
        check("T5_pre_read", read, 4'b0001);
        check("T5_pre_valid", hit_valid, 1'b1);
        reset_sched = 1'b1;
        #1;
        check_reset_outputs("T5");
        tick();
        reset_sched = 1'b0;
        n_frames    = 8'd0;
        exp_q.delete();
        tick();
        run_frame(4'b0001, 70, 1'b0, "T5_after");

`ifdef HIT_FRAME_ID_EN
        // T6: empty frames until the id wraps, then a frame with a hit
        while (n_frames != 8'd0) run_frame(4'b0000, 100, 1'b0, "T6_fill");
        mask[1] = 8'b0010_0000;
        run_frame(4'b0010, 100, 1'b1, "T6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
